// File: rtl/time_pkg.sv
// Shared types and helpers for the HH:MM set controller: state encoding,
// field limits and a divider-free binary-to-BCD split.
package time_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_SET_HOUR = 2'd1,
    S_SET_MIN  = 2'd2,
    S_COMMIT   = 2'd3
  } state_e;

  localparam logic [4:0] MAX_HOUR  = 5'd23;
  localparam logic [5:0] MAX_MIN   = 6'd59;

  localparam logic [1:0] DISP_RUN  = 2'b00;
  localparam logic [1:0] DISP_HOUR = 2'b01;
  localparam logic [1:0] DISP_MIN  = 2'b10;

  // Binary 0..59 to {tens[2:0], units[3:0]} using a compare chain.
  function automatic logic [6:0] to_bcd(input logic [5:0] bin);
    logic [2:0] tens;
    logic [3:0] units;
    if (bin >= 6'd50) begin
      tens  = 3'd5;
      units = 4'(bin - 6'd50);
    end else if (bin >= 6'd40) begin
      tens  = 3'd4;
      units = 4'(bin - 6'd40);
    end else if (bin >= 6'd30) begin
      tens  = 3'd3;
      units = 4'(bin - 6'd30);
    end else if (bin >= 6'd20) begin
      tens  = 3'd2;
      units = 4'(bin - 6'd20);
    end else if (bin >= 6'd10) begin
      tens  = 3'd1;
      units = 4'(bin - 6'd10);
    end else begin
      tens  = 3'd0;
      units = 4'(bin);
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button, counter-readback and load/enable bundle between the set controller
// (slave) and its environment (master).
interface time_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] u_min_in;
  logic [2:0] z_min_in;
  logic [3:0] u_hour_in;
  logic [1:0] z_hour_in;
  logic       cnt_en;
  logic       cnt_load;
  logic [3:0] u_min_ld;
  logic [2:0] z_min_ld;
  logic [3:0] u_hour_ld;
  logic [1:0] z_hour_ld;
  logic [1:0] disp_sel;

  modport master (
    output btn_mode, btn_inc, u_min_in, z_min_in, u_hour_in, z_hour_in,
    input  cnt_en, cnt_load, u_min_ld, z_min_ld, u_hour_ld, z_hour_ld, disp_sel
  );

  modport slave (
    input  btn_mode, btn_inc, u_min_in, z_min_in, u_hour_in, z_hour_in,
    output cnt_en, cnt_load, u_min_ld, z_min_ld, u_hour_ld, z_hour_ld, disp_sel
  );
endinterface

// File: rtl/tick_prescaler.sv
// Minute divider: counts 0..TICKS_PER_MIN-1 while run is high, holds otherwise,
// and flags the last count of each minute as a one-cycle tick.
module tick_prescaler #(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICKS_PER_MIN);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MIN - 1);

  logic [CW-1:0] count_r;

  // Prescaler count: clear beats run; count freezes outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (run) begin
      count_r <= (count_r == LAST) ? '0 : count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tick = run && (count_r == LAST);

endmodule

// File: rtl/time_set_ctrl.sv
// HH:MM sequencer: per-minute count enable plus a mode/inc button set FSM that
// commits the edited time as a one-cycle BCD load. Optional macro
// TIME_SET_TIMEOUT_EN aborts an idle edit after TIMEOUT_CYCLES cycles.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int TICKS_PER_MIN  = 60,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic            clk,
  input logic            rst,
  time_set_ctrl_if.slave bus
);

  state_e     state_r;
  logic [4:0] edit_hour_r;
  logic [5:0] edit_min_r;
  logic       cnt_load_r;
  logic [1:0] disp_sel_r;
  logic [3:0] u_min_ld_r;
  logic [2:0] z_min_ld_r;
  logic [3:0] u_hour_ld_r;
  logic [1:0] z_hour_ld_r;

  logic       tick_s;
  logic       timeout_s;
  logic [6:0] raw_hour_s;
  logic [6:0] raw_min_s;
  logic [4:0] cap_hour_s;
  logic [5:0] cap_min_s;
  logic [6:0] bcd_hour_s;
  logic [6:0] bcd_min_s;

  tick_prescaler #(.TICKS_PER_MIN(TICKS_PER_MIN)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (state_r == S_RUN),
    .clear (state_r == S_COMMIT),
    .tick  (tick_s)
  );

  // Capture path: BCD readback to binary, saturated into 00:00..23:59.
  always_comb begin
    raw_hour_s = ({5'd0, bus.z_hour_in} * 7'd10) + {3'd0, bus.u_hour_in};
    raw_min_s  = ({4'd0, bus.z_min_in} * 7'd10) + {3'd0, bus.u_min_in};
    cap_hour_s = (raw_hour_s > {2'd0, MAX_HOUR}) ? MAX_HOUR : raw_hour_s[4:0];
    cap_min_s  = (raw_min_s > {1'd0, MAX_MIN}) ? MAX_MIN : raw_min_s[5:0];
    bcd_hour_s = to_bcd({1'b0, edit_hour_r});
    bcd_min_s  = to_bcd(edit_min_r);
  end

`ifdef TIME_SET_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_r;
  logic              in_set_s;

  assign in_set_s  = (state_r == S_SET_HOUR) || (state_r == S_SET_MIN);
  assign timeout_s = in_set_s && (idle_r == IDLE_LAST);

  // Idle counter: only runs in a set state with no button; anything else clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_r <= '0;
    end else if (in_set_s && !bus.btn_mode && !bus.btn_inc) begin
      idle_r <= idle_r + IDLE_W'(1);
    end else begin
      idle_r <= '0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Set FSM with registered load strobe, load values and display select.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_RUN;
      edit_hour_r <= 5'd0;
      edit_min_r  <= 6'd0;
      cnt_load_r  <= 1'b0;
      disp_sel_r  <= DISP_RUN;
      u_min_ld_r  <= 4'd0;
      z_min_ld_r  <= 3'd0;
      u_hour_ld_r <= 4'd0;
      z_hour_ld_r <= 2'd0;
    end else begin
      cnt_load_r <= 1'b0;
      case (state_r)
        S_RUN: begin
          if (bus.btn_mode) begin
            state_r     <= S_SET_HOUR;
            edit_hour_r <= cap_hour_s;
            edit_min_r  <= cap_min_s;
            disp_sel_r  <= DISP_HOUR;
          end else begin
            disp_sel_r  <= DISP_RUN;
          end
        end
        S_SET_HOUR: begin
          if (bus.btn_mode) begin
            state_r     <= S_SET_MIN;
            disp_sel_r  <= DISP_MIN;
          end else if (bus.btn_inc) begin
            edit_hour_r <= (edit_hour_r == MAX_HOUR) ? 5'd0 : edit_hour_r + 5'd1;
          end else if (timeout_s) begin
            state_r     <= S_RUN;
            disp_sel_r  <= DISP_RUN;
          end else begin
            disp_sel_r  <= DISP_HOUR;
          end
        end
        S_SET_MIN: begin
          if (bus.btn_mode) begin
            // Load values are latched here so they are valid during COMMIT.
            state_r     <= S_COMMIT;
            cnt_load_r  <= 1'b1;
            disp_sel_r  <= DISP_RUN;
            z_hour_ld_r <= 2'(bcd_hour_s[6:4]);
            u_hour_ld_r <= bcd_hour_s[3:0];
            z_min_ld_r  <= bcd_min_s[6:4];
            u_min_ld_r  <= bcd_min_s[3:0];
          end else if (bus.btn_inc) begin
            edit_min_r  <= (edit_min_r == MAX_MIN) ? 6'd0 : edit_min_r + 6'd1;
          end else if (timeout_s) begin
            state_r     <= S_RUN;
            disp_sel_r  <= DISP_RUN;
          end else begin
            disp_sel_r  <= DISP_MIN;
          end
        end
        S_COMMIT: begin
          state_r    <= S_RUN;
          disp_sel_r <= DISP_RUN;
        end
        default: begin
          state_r    <= S_RUN;
          disp_sel_r <= DISP_RUN;
        end
      endcase
    end
  end

  assign bus.cnt_en    = tick_s;
  assign bus.cnt_load  = cnt_load_r;
  assign bus.u_min_ld  = u_min_ld_r;
  assign bus.z_min_ld  = z_min_ld_r;
  assign bus.u_hour_ld = u_hour_ld_r;
  assign bus.z_hour_ld = z_hour_ld_r;
  assign bus.disp_sel  = disp_sel_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random buttons/inputs against
// a cycle-level time-of-day reference model.
module tb_time_set_ctrl;

  localparam int T  = 4;
  localparam int TO = 8;
`ifdef TIME_SET_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int P_RUN = 0, P_HOUR = 1, P_MIN = 2, P_COMMIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  time_set_ctrl_if bus();

  time_set_ctrl #(.TICKS_PER_MIN(T), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase, minute prescaler, edited and last-loaded times.
  int ph = P_RUN, pre = 0, eh = 0, em = 0, ldh = 0, ldm = 0, idle = 0;
  int in_zh = 0, in_uh = 0, in_zm = 0, in_um = 0;

  logic [16:0] obs;
  assign obs = {bus.cnt_en, bus.cnt_load, bus.z_hour_ld, bus.u_hour_ld,
                bus.z_min_ld, bus.u_min_ld, bus.disp_sel};

  function automatic logic [16:0] exp_obs();
    logic [1:0] d;
    d = (ph == P_HOUR) ? 2'd1 : ((ph == P_MIN) ? 2'd2 : 2'd0);
    return {(ph == P_RUN) && (pre == T - 1), ph == P_COMMIT,
            2'(ldh / 10), 4'(ldh % 10), 3'(ldm / 10), 4'(ldm % 10), d};
  endfunction

  task automatic model_edge(input bit r, input bit m, input bit i);
    int hh, mm;
    if (r) begin
      ph = P_RUN; pre = 0; eh = 0; em = 0; ldh = 0; ldm = 0; idle = 0;
    end else begin
      case (ph)
        P_RUN: begin
          pre = (pre + 1) % T;
          if (m) begin
            hh = 10 * in_zh + in_uh;
            mm = 10 * in_zm + in_um;
            eh = (hh > 23) ? 23 : hh;
            em = (mm > 59) ? 59 : mm;
            ph = P_HOUR;
            idle = 0;
          end
        end
        P_HOUR, P_MIN: begin
          if (m) begin
            if (ph == P_HOUR) ph = P_MIN;
            else begin ph = P_COMMIT; ldh = eh; ldm = em; end
            idle = 0;
          end else if (i) begin
            if (ph == P_HOUR) eh = (eh + 1) % 24;
            else em = (em + 1) % 60;
            idle = 0;
          end else if (TO_EN && idle == TO - 1) begin
            ph = P_RUN;
            idle = 0;
          end else begin
            idle = idle + 1;
          end
        end
        default: begin ph = P_RUN; pre = 0; end
      endcase
    end
  endtask

  task automatic step(input bit r, input bit m, input bit i);
    rst = r; bus.btn_mode = m; bus.btn_inc = i;
    @(posedge clk);
    model_edge(r, m, i);
    #1;
    rst = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
  endtask

  task automatic set_time(input int zh, input int uh, input int zm, input int um);
    in_zh = zh; in_uh = uh; in_zm = zm; in_um = um;
    bus.z_hour_in = 2'(zh); bus.u_hour_in = 4'(uh);
    bus.z_min_in  = 3'(zm); bus.u_min_in  = 4'(um);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    total++;
    if (obs !== 17'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, 17'd0); end
    total++;
    if (obs !== exp_obs()) begin bad++; $display("FAIL reset_model got=%h exp=%h", obs, exp_obs()); end
  endtask

  task automatic test_run_ticks();
    for (int k = 1; k <= 12; k++) begin
      total++;
      if (bus.cnt_en !== ((k % 4) == 0)) begin
        bad++; $display("FAIL run_tick k=%0d got=%b exp=%b", k, bus.cnt_en, (k % 4) == 0);
      end
      total++;
      if (obs !== exp_obs()) begin bad++; $display("FAIL run_model k=%0d got=%h exp=%h", k, obs, exp_obs()); end
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_set_wrap();
    bit [1:0] seq [4];
    seq = '{2'b10, 2'b01, 2'b10, 2'b10};
    set_time(2, 3, 5, 9);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, seq[k][1], seq[k][0]);
      total++;
      if (bus.cnt_en !== 1'b0) begin bad++; $display("FAIL wrap_cnt_en k=%0d got=%b exp=0", k, bus.cnt_en); end
      total++;
      if (obs !== exp_obs()) begin bad++; $display("FAIL wrap_model k=%0d got=%h exp=%h", k, obs, exp_obs()); end
    end
    total++;
    if ({bus.cnt_load, bus.z_hour_ld, bus.u_hour_ld, bus.z_min_ld, bus.u_min_ld} !== {1'b1, 2'd0, 4'd0, 3'd5, 4'd9}) begin
      bad++; $display("FAIL wrap_load got=%b %0d%0d:%0d%0d exp=1 00:59", bus.cnt_load,
                      bus.z_hour_ld, bus.u_hour_ld, bus.z_min_ld, bus.u_min_ld);
    end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (obs !== exp_obs() || bus.cnt_load !== 1'b0) begin
      bad++; $display("FAIL wrap_after got=%h exp=%h", obs, exp_obs());
    end
  endtask

  task automatic test_no_carry();
    bit [1:0] seq [4];
    seq = '{2'b10, 2'b10, 2'b01, 2'b10};
    set_time(0, 7, 5, 9);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, seq[k][1], seq[k][0]);
      total++;
      if (obs !== exp_obs()) begin bad++; $display("FAIL nocarry_model k=%0d got=%h exp=%h", k, obs, exp_obs()); end
    end
    total++;
    if ({bus.cnt_load, bus.z_hour_ld, bus.u_hour_ld, bus.z_min_ld, bus.u_min_ld} !== {1'b1, 2'd0, 4'd7, 3'd0, 4'd0}) begin
      bad++; $display("FAIL nocarry_load got=%b %0d%0d:%0d%0d exp=1 07:00", bus.cnt_load,
                      bus.z_hour_ld, bus.u_hour_ld, bus.z_min_ld, bus.u_min_ld);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mode_inc_same();
    set_time(0, 5, 3, 0);
    step(1'b0, 1'b1, 1'b0);
    total++;
    if (bus.disp_sel !== 2'b01) begin bad++; $display("FAIL same_hour_disp got=%b exp=01", bus.disp_sel); end
    step(1'b0, 1'b1, 1'b1);
    total++;
    if (bus.disp_sel !== 2'b10) begin bad++; $display("FAIL same_min_disp got=%b exp=10", bus.disp_sel); end
    total++;
    if (obs !== exp_obs()) begin bad++; $display("FAIL same_model got=%h exp=%h", obs, exp_obs()); end
    step(1'b0, 1'b1, 1'b0);
    total++;
    if ({bus.cnt_load, bus.z_hour_ld, bus.u_hour_ld, bus.z_min_ld, bus.u_min_ld} !== {1'b1, 2'd0, 4'd5, 3'd3, 4'd0}) begin
      bad++; $display("FAIL same_load got=%b %0d%0d:%0d%0d exp=1 05:30", bus.cnt_load,
                      bus.z_hour_ld, bus.u_hour_ld, bus.z_min_ld, bus.u_min_ld);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_idle();
    int exp_d;
    step(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      exp_d = (TO_EN && k > TO) ? 0 : 1;
      total++;
      if (bus.disp_sel !== 2'(exp_d) || bus.cnt_load !== 1'b0) begin
        bad++; $display("FAIL idle_disp k=%0d got=%b/%b exp=%0d/0", k, bus.disp_sel, bus.cnt_load, exp_d);
      end
      total++;
      if (obs !== exp_obs()) begin bad++; $display("FAIL idle_model k=%0d got=%h exp=%h", k, obs, exp_obs()); end
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_edit();
    set_time(1, 2, 3, 4);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    total++;
    if (bus.disp_sel !== 2'b10) begin bad++; $display("FAIL midrst_pre_disp got=%b exp=10", bus.disp_sel); end
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (bus.disp_sel !== 2'b00 || bus.cnt_load !== 1'b0 || bus.cnt_en !== (k == 4)) begin
        bad++; $display("FAIL midrst k=%0d got disp=%b load=%b en=%b exp 00/0/%b", k,
                        bus.disp_sel, bus.cnt_load, bus.cnt_en, k == 4);
      end
      total++;
      if (obs !== exp_obs()) begin bad++; $display("FAIL midrst_model k=%0d got=%h exp=%h", k, obs, exp_obs()); end
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random();
    bit r, m, i;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0)
        set_time($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15));
      r = ($urandom_range(0, 199) == 0);
      m = ($urandom_range(0, 5) == 0);
      i = ($urandom_range(0, 2) == 0);
      step(r, m, i);
      total++;
      if (obs !== exp_obs()) begin bad++; $display("FAIL rand_model n=%0d got=%h exp=%h", n, obs, exp_obs()); end
      total++;
      if ((bus.cnt_en & bus.cnt_load) !== 1'b0) begin
        bad++; $display("FAIL rand_en_load n=%0d got=%b exp=0", n, bus.cnt_en & bus.cnt_load);
      end
    end
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    set_time(0, 0, 0, 0);
    test_reset();
    test_run_ticks();
    test_set_wrap();
    test_no_carry();
    test_mode_inc_same();
    test_idle();
    test_reset_mid_edit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
